// File: rtl/di_arb_pkg.sv
// ---------------------------------------------------------------------------
// di_arb_pkg
// Shared definitions for the Device Interface register-bus arbiter:
//   - arb_state_t : FSM state encoding (IDLE/ISSUE/WAIT/DONE)
//   - TIMEOUT_RDATA : read data returned when a transfer is abandoned by the
//                     watchdog (only meaningful with DI_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
package di_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

endpackage : di_arb_pkg

// File: rtl/di_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority selector. Returns the first set bit of
// req found by searching upward from ptr, wrapping modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDXW     search start index (expected < NUM_REQ)
//   valid out 1        any request set
//   idx   out IDXW     selected index (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDXW    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDXW-1:0]    ptr,
   output logic               valid,
   output logic [IDXW-1:0]    idx
);

   // Position that is 'off' steps above 'base', wrapped into 0..NUM_REQ-1.
   function automatic int wrap_idx(input int base, input int off);
      return (base + off) % NUM_REQ;
   endfunction

   // Walk offsets from farthest to nearest so the nearest match is the one
   // left standing after the loop.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if ((j == wrap_idx(int'(ptr), k)) && req[j]) begin
               valid = 1'b1;
               idx   = IDXW'(j);
            end
         end
      end
   end

endmodule : rr_pick

// File: rtl/di_arbiter.sv
// ---------------------------------------------------------------------------
// di_arbiter
// Round-robin arbiter sharing one Device Interface register bus between
// NUM_REQ requesters. One transaction per grant:
//   IDLE -> ISSUE (one-cycle diWrite/diRead) -> WAIT (for rdwr_ready)
//        -> DONE (req_done pulse to grantee) -> IDLE
// Optional watchdog: define DI_ARB_TIMEOUT_EN to abandon a WAIT after
// TIMEOUT cycles, returning 16'hDEAD with req_err set.
// Ports:
//   if_clock, resetb                 clock, async active-low reset
//   req/req_write                    per-requester request and direction
//   req_ep_addr/req_reg_addr/req_wdata  16 bits per requester, packed
//   req_done/req_rdata/req_err       completion back to the grantee
//   grant_idx, busy                  status
//   diEpAddr/diRegAddr/diRegDataIn   downstream address/data
//   diWrite/diRead                   downstream one-cycle strobes
//   diRegDataOut/rdwr_ready          downstream read data and ready
// ---------------------------------------------------------------------------
module di_arbiter
   import di_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDXW    = 1,
   parameter int TIMEOUT = 255
) (
   input  logic                  if_clock,
   input  logic                  resetb,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [16*NUM_REQ-1:0] req_ep_addr,
   input  logic [16*NUM_REQ-1:0] req_reg_addr,
   input  logic [16*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    req_done,
   output logic [15:0]           req_rdata,
   output logic                  req_err,
   output logic [IDXW-1:0]       grant_idx,
   output logic                  busy,
   output logic [15:0]           diEpAddr,
   output logic [15:0]           diRegAddr,
   output logic [15:0]           diRegDataIn,
   input  logic [15:0]           diRegDataOut,
   output logic                  diWrite,
   output logic                  diRead,
   input  logic                  rdwr_ready
);

   arb_state_t           state_q, state_d;
   logic [IDXW-1:0]      ptr_q, ptr_d;
   logic [IDXW-1:0]      grant_q, grant_d;
   logic                 write_q, write_d;
   logic [15:0]          ep_q, ep_d;
   logic [15:0]          reg_q, reg_d;
   logic [15:0]          wdata_q, wdata_d;
   logic [15:0]          rdata_q, rdata_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 diwrite_q, diwrite_d;
   logic                 diread_q, diread_d;
   logic [NUM_REQ-1:0]   grant_onehot;

   logic                 pick_valid;
   logic [IDXW-1:0]      pick_idx;

`ifdef DI_ARB_TIMEOUT_EN
   localparam int CNTW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic                 err_q, err_d;
`endif

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      grant_onehot = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         grant_onehot[j] = (IDXW'(j) == grant_q);
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      write_d   = write_q;
      ep_d      = ep_q;
      reg_d     = reg_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      done_d    = '0;
      diwrite_d = 1'b0;
      diread_d  = 1'b0;
`ifdef DI_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               // Mux the winner's fields with a constant-index loop so each
               // slice stays a fixed 16-bit part-select.
               for (int j = 0; j < NUM_REQ; j++) begin
                  if (IDXW'(j) == pick_idx) begin
                     write_d = req_write[j];
                     ep_d    = req_ep_addr[16*j +: 16];
                     reg_d   = req_reg_addr[16*j +: 16];
                     wdata_d = req_wdata[16*j +: 16];
                  end
               end
               // Strobes are registered so they are high exactly during ISSUE.
               diwrite_d = write_d;
               diread_d  = ~write_d;
               state_d   = ISSUE;
            end
         end

         ISSUE: begin
            // Ready seen here is deliberately ignored; WAIT samples it.
`ifdef DI_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = WAIT;
         end

         WAIT: begin
            if (rdwr_ready) begin
               if (!write_q) begin
                  rdata_d = diRegDataOut;
               end
               done_d  = grant_onehot;
               state_d = DONE;
            end
`ifdef DI_ARB_TIMEOUT_EN
            // Counter holds 0 in the first WAIT cycle, so hitting TIMEOUT-1
            // means TIMEOUT WAIT cycles have elapsed. Ready has priority.
            else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
               rdata_d = TIMEOUT_RDATA;
               err_d   = 1'b1;
               done_d  = grant_onehot;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         DONE: begin
            if (grant_q == IDXW'(NUM_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = grant_q + 1'b1;
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         write_q   <= 1'b0;
         ep_q      <= '0;
         reg_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         done_q    <= '0;
         diwrite_q <= 1'b0;
         diread_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         write_q   <= write_d;
         ep_q      <= ep_d;
         reg_q     <= reg_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         diwrite_q <= diwrite_d;
         diread_q  <= diread_d;
      end
   end

`ifdef DI_ARB_TIMEOUT_EN
   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign req_err = err_q;
`else
   assign req_err = 1'b0;
`endif

   assign req_done    = done_q;
   assign req_rdata   = rdata_q;
   assign grant_idx   = grant_q;
   assign busy        = (state_q != IDLE);
   assign diEpAddr    = ep_q;
   assign diRegAddr   = reg_q;
   assign diRegDataIn = wdata_q;
   assign diWrite     = diwrite_q;
   assign diRead      = diread_q;

endmodule : di_arbiter

// File: tb/tb_di_arbiter.sv
// ---------------------------------------------------------------------------
// tb_di_arbiter
// Directed bench for di_arbiter (NUM_REQ=2, TIMEOUT=8). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_di_arbiter;

   localparam int NUM_REQ = 2;
   localparam int IDXW    = 1;
   localparam int TIMEOUT = 8;

   logic                  clk;
   logic                  resetb;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_write;
   logic [16*NUM_REQ-1:0] req_ep_addr;
   logic [16*NUM_REQ-1:0] req_reg_addr;
   logic [16*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]    req_done;
   logic [15:0]           req_rdata;
   logic                  req_err;
   logic [IDXW-1:0]       grant_idx;
   logic                  busy;
   logic [15:0]           diEpAddr;
   logic [15:0]           diRegAddr;
   logic [15:0]           diRegDataIn;
   logic [15:0]           diRegDataOut;
   logic                  diWrite;
   logic                  diRead;
   logic                  rdwr_ready;

   int n_chk  = 0;
   int n_pass = 0;

   di_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .if_clock     (clk),
      .resetb       (resetb),
      .req          (req),
      .req_write    (req_write),
      .req_ep_addr  (req_ep_addr),
      .req_reg_addr (req_reg_addr),
      .req_wdata    (req_wdata),
      .req_done     (req_done),
      .req_rdata    (req_rdata),
      .req_err      (req_err),
      .grant_idx    (grant_idx),
      .busy         (busy),
      .diEpAddr     (diEpAddr),
      .diRegAddr    (diRegAddr),
      .diRegDataIn  (diRegDataIn),
      .diRegDataOut (diRegDataOut),
      .diWrite      (diWrite),
      .diRead       (diRead),
      .rdwr_ready   (rdwr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetb       = 1'b0;
      req          = '0;
      req_write    = '0;
      req_ep_addr  = '0;
      req_reg_addr = '0;
      req_wdata    = '0;
      diRegDataOut = 16'h0000;
      rdwr_ready   = 1'b0;
      tick();
      tick();

      // ---------------- reset state ----------------
      check("rst_done",  req_done,  0);
      check("rst_busy",  busy,      0);
      check("rst_grant", grant_idx, 0);
      check("rst_strb",  {diWrite, diRead}, 0);
      check("rst_rdata", req_rdata, 0);
      check("rst_ep",    diEpAddr,  0);
      check("rst_err",   req_err,   0);
      resetb = 1'b1;
      tick();

      // ---------------- single write, ready 2 cycles after strobe ----------
      req          = 2'b01;
      req_write    = 2'b01;
      req_ep_addr  = {16'h7777, 16'h0003};
      req_reg_addr = {16'h8888, 16'h0010};
      req_wdata    = {16'h9999, 16'hA5A5};
      tick();                                   // ISSUE
      check("wr_strobe", {diWrite, diRead}, 2'b10);
      check("wr_ep",     diEpAddr,    16'h0003);
      check("wr_reg",    diRegAddr,   16'h0010);
      check("wr_wdata",  diRegDataIn, 16'hA5A5);
      check("wr_grant",  grant_idx,   0);
      check("wr_busy",   busy,        1);
      tick();                                   // WAIT 1
      check("wr_strobe_1cyc", {diWrite, diRead}, 2'b00);
      tick();                                   // WAIT 2
      check("wr_nodone_wait", req_done, 0);
      rdwr_ready = 1'b1;
      tick();                                   // DONE
      check("wr_done",   req_done,  2'b01);
      check("wr_rdata",  req_rdata, 16'h0000);
      check("wr_ep_hold", diEpAddr, 16'h0003);
      check("wr_err",    req_err,   0);
      rdwr_ready = 1'b0;
      req        = 2'b00;
      tick();                                   // IDLE
      check("wr_done_clr", req_done, 0);
      check("wr_idle",     busy,     0);

      // ---------------- single read from requester 1 ----------------
      req          = 2'b10;
      req_write    = 2'b00;
      req_ep_addr  = {16'h0021, 16'h0000};
      req_reg_addr = {16'h0042, 16'h0000};
      diRegDataOut = 16'h1234;
      tick();                                   // ISSUE
      check("rd_strobe", {diWrite, diRead}, 2'b01);
      check("rd_grant",  grant_idx, 1);
      check("rd_ep",     diEpAddr,  16'h0021);
      tick();                                   // WAIT 1
      check("rd_nodone_wait", req_done, 0);
      rdwr_ready = 1'b1;
      tick();                                   // DONE, 4th cycle
      check("rd_done",  req_done,  2'b10);
      check("rd_rdata", req_rdata, 16'h1234);
      rdwr_ready = 1'b0;
      req        = 2'b00;
      tick();                                   // IDLE

      // ---------------- contention with ready tied high ----------------
      // Pointer is 0 after requester 1 finished. Ready high during ISSUE
      // must not shorten the transaction.
      req          = 2'b11;
      req_write    = 2'b00;
      diRegDataOut = 16'h5A5A;
      rdwr_ready   = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();                                // ISSUE
         check("rr_grant",  grant_idx, t % 2);
         check("rr_strobe", {diWrite, diRead}, 2'b01);
         tick();                                // WAIT
         check("rr_strobe_1cyc", {diWrite, diRead}, 2'b00);
         check("rr_nodone_wait", req_done, 0);
         tick();                                // DONE
         check("rr_done", req_done, (t % 2 == 0) ? 2'b01 : 2'b10);
         tick();                                // IDLE
         check("rr_done_clr", req_done, 0);
         check("rr_idle",     busy,     0);
      end
      check("rr_rdata", req_rdata, 16'h5A5A);
      req        = 2'b00;
      rdwr_ready = 1'b0;
      tick();

      // ---------------- reset mid-WAIT ----------------
      // First move the pointer to 1 by completing a requester-0 transfer.
      req        = 2'b01;
      rdwr_ready = 1'b1;
      tick();                                   // ISSUE
      tick();                                   // WAIT
      tick();                                   // DONE
      check("pre_rst_done", req_done, 2'b01);
      req        = 2'b00;
      rdwr_ready = 1'b0;
      tick();                                   // IDLE, pointer now 1
      req          = 2'b10;
      req_ep_addr  = {16'hBEEF, 16'h0000};
      tick();                                   // ISSUE grant 1
      check("pre_rst_grant", grant_idx, 1);
      tick();                                   // WAIT
      check("pre_rst_busy", busy, 1);
      #2;
      resetb = 1'b0;
      #1;
      check("mid_rst_busy",  busy,      0);
      check("mid_rst_grant", grant_idx, 0);
      check("mid_rst_ep",    diEpAddr,  0);
      check("mid_rst_rdata", req_rdata, 0);
      check("mid_rst_strb",  {diWrite, diRead}, 0);
      rdwr_ready = 1'b1;
      tick();
      tick();
      check("in_rst_done", req_done, 0);
      resetb     = 1'b1;
      rdwr_ready = 1'b0;
      req        = 2'b11;
      tick();                                   // ISSUE
      check("post_rst_grant", grant_idx, 0);
      rdwr_ready = 1'b1;
      tick();                                   // WAIT
      tick();                                   // DONE
      check("post_rst_done", req_done, 2'b01);
      req        = 2'b00;
      rdwr_ready = 1'b0;
      tick();
      check("post_rst_err", req_err, 0);

`ifdef DI_ARB_TIMEOUT_EN
      // ---------------- watchdog timeout ----------------
      req          = 2'b01;
      req_write    = 2'b00;
      diRegDataOut = 16'h4321;
      tick();                                   // ISSUE
      tick();                                   // WAIT entry
      for (int w = 0; w < TIMEOUT - 1; w++) begin
         check("to_wait_nodone", req_done, 0);
         tick();
      end
      check("to_last_wait_busy", busy, 1);
      tick();                                   // DONE
      check("to_done",  req_done,  2'b01);
      check("to_err",   req_err,   1);
      check("to_rdata", req_rdata, 16'hDEAD);
      req = 2'b00;
      tick();
      check("to_err_clr", req_err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_di_arbiter
